// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin grant over four requesters feeding a 4:1 mux
// into a single-stage valid/ready output buffer.
module rr_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);
  logic [1:0]       r_ptr;
  logic             w_load;
  logic             w_any;
  logic [1:0]       w_win;
  logic [WIDTH-1:0] w_data;
  assign w_load = !out_valid || out_ready;
  // Scan from the farthest slot back to ptr so the nearest requester wins last.
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[r_ptr + 2'(k)]) begin
        w_any = 1'b1;
        w_win = r_ptr + 2'(k);
      end
    end
  end
  assign w_data   = w_win[1] ? (w_win[0] ? d3 : d2) : (w_win[0] ? d1 : d0);
  assign in_ready = (rst_n && w_load && w_any) ? (4'b0001 << w_win) : 4'b0000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      r_ptr     <= 2'd0;
    end else if (w_load) begin
      out_valid <= w_any;
      if (w_any) begin
        out_data <= w_data;
        out_sel  <= w_win;
        r_ptr    <= w_win + 2'd1;
      end
    end
  end
endmodule
